// File: rtl/cache_writeback_buffer_pkg.sv
// cache_writeback_buffer_pkg: shared LC-3b line types and fill-level helper for the writeback buffer
package cache_writeback_buffer_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0] lc3b_line_tag;
  typedef struct packed {
    lc3b_line_tag tag;
    lc3b_line line;
  } wb_entry_t;
  typedef enum logic [1:0] {WB_EMPTY, WB_PARTIAL, WB_FULL} wb_level_e;
  function automatic wb_level_e level_of(input int count, input int entries);
    return count == 0 ? WB_EMPTY : count == entries ? WB_FULL : WB_PARTIAL;
  endfunction
endpackage

// File: rtl/wb_entry_match.sv
// wb_entry_match: per-entry tag compare, newest valid match wins
module wb_entry_match
  import cache_writeback_buffer_pkg::*;
#(
  parameter int ENTRIES = 2,
  parameter int PW = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  wb_entry_t          entries [ENTRIES],
  input  logic [PW-1:0]      tail,
  input  lc3b_line_tag       tag,
  output logic               hit,
  output lc3b_line           line
);
  logic [PW-1:0] idx;
  // walk backwards from the newest entry (tail-1) so the first hit is the youngest
  always_comb begin
    hit = 1'b0;
    line = '0;
    idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      idx = tail - PW'(i + 1);
      if (!hit && valid[idx] && entries[idx].tag == tag) begin
        hit = 1'b1;
        line = entries[idx].line;
      end
    end
  end
endmodule

// File: rtl/cache_writeback_buffer.sv
// cache_writeback_buffer: FIFO of evicted dirty lines drained to pmem, with probe forwarding
module cache_writeback_buffer
  import cache_writeback_buffer_pkg::*;
#(
  parameter int ENTRIES = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     wb_req,
  input  lc3b_word wb_addr,
  input  lc3b_line wb_line,
  output logic     wb_ready,
  input  lc3b_word probe_addr,
  output logic     probe_hit,
  output lc3b_line probe_line,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  output logic     pmem_write,
  input  logic     pmem_resp,
  output logic     empty
);
  localparam int PW = $clog2(ENTRIES);
  localparam int CW = PW + 1;
  wb_entry_t mem [ENTRIES];
  logic [PW-1:0] head, tail, off;
  logic [CW-1:0] count;
  logic [ENTRIES-1:0] valid;
  logic push, pop;
  wb_level_e level;
  logic unused;
  assign unused = ^{wb_addr[3:0], probe_addr[3:0]};
  assign level = level_of(int'(count), ENTRIES);
  assign wb_ready = level != WB_FULL;
  assign empty = level == WB_EMPTY;
  assign pmem_write = !empty;
  assign push = wb_req && wb_ready;
  assign pop = pmem_resp && !empty;
  assign pmem_address = {mem[head].tag, 4'h0};
  assign pmem_wdata = mem[head].line;
  // an entry is live when its distance from head is below count
  always_comb begin
    valid = '0;
    off = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      off = PW'(j) - head;
      valid[j] = {1'b0, off} < count;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else begin
      if (push) mem[tail] <= '{tag: wb_addr[15:4], line: wb_line};
      tail <= tail + PW'(push);
      head <= head + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  wb_entry_match #(.ENTRIES(ENTRIES), .PW(PW)) u_match (
    .valid(valid),
    .entries(mem),
    .tail(tail),
    .tag(probe_addr[15:4]),
    .hit(probe_hit),
    .line(probe_line)
  );
endmodule

// File: tb/tb_cache_writeback_buffer.sv
// tb_cache_writeback_buffer: directed + random stimulus checked against a queue model
module tb_cache_writeback_buffer;
  localparam int ENTRIES = 2;
  typedef struct {
    logic [11:0] tag;
    logic [127:0] line;
  } ent_t;
  logic clk = 1'b0, reset = 1'b1, wb_req = 1'b0, pmem_resp = 1'b0;
  logic [15:0] wb_addr = '0, probe_addr = '0;
  logic [127:0] wb_line = '0;
  logic wb_ready, probe_hit, pmem_write, empty;
  logic [127:0] probe_line, pmem_wdata;
  logic [15:0] pmem_address;
  ent_t q[$];
  logic [15:0] wlog[$];
  int vectors = 0, miscompares = 0;
  localparam logic [127:0] LA5 = {16{8'hA5}};
  localparam logic [127:0] LX = {4{32'h1111_2222}};
  localparam logic [127:0] LY = {4{32'h3333_4444}};

  cache_writeback_buffer #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset(reset), .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line),
    .wb_ready(wb_ready), .probe_addr(probe_addr), .probe_hit(probe_hit), .probe_line(probe_line),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_model();
    logic hit;
    logic [127:0] line;
    hit = 1'b0;
    line = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!hit && q[i].tag == probe_addr[15:4]) begin
        hit = 1'b1;
        line = q[i].line;
      end
    chk("wb_ready", wb_ready, q.size() < ENTRIES);
    chk("empty", empty, q.size() == 0);
    chk("pmem_write", pmem_write, q.size() != 0);
    chk("probe_hit", probe_hit, hit);
    chk("probe_line", probe_line, line);
    if (q.size() != 0) begin
      chk("pmem_address", pmem_address, {q[0].tag, 4'h0});
      chk("pmem_wdata", pmem_wdata, q[0].line);
    end
  endtask

  task automatic step(input logic req, input logic [15:0] a, input logic [127:0] l,
                      input logic resp, input logic [15:0] pa, input logic rs);
    bit do_push, do_pop;
    @(negedge clk);
    wb_req = req; wb_addr = a; wb_line = l; pmem_resp = resp; probe_addr = pa; reset = rs;
    #1 compare_model();
    @(posedge clk);
    if (rs) q.delete();
    else begin
      do_push = req && q.size() < ENTRIES;
      do_pop = resp && q.size() != 0;
      if (do_pop) begin
        wlog.push_back({q[0].tag, 4'h0});
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{tag: a[15:4], line: l});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    // reset
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b0);
    chk("rst_ready", wb_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_probe_hit", probe_hit, 1'b0);
    chk("rst_pmem_address", pmem_address, 16'h0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_probe_line", probe_line, '0);
    // single line
    step(1'b1, 16'h1234, LA5, 1'b0, 16'h0, 1'b0);
    chk("single_write", pmem_write, 1'b1);
    chk("single_addr", pmem_address, 16'h1230);
    chk("single_data", pmem_wdata, LA5);
    idle(4);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, 1'b0);
    chk("single_empty", empty, 1'b1);
    chk("single_write_low", pmem_write, 1'b0);
    // full / backpressure
    wlog.delete();
    step(1'b1, 16'h0100, {8{16'h0100}}, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0200, {8{16'h0200}}, 1'b0, 16'h0, 1'b0);
    chk("full_ready", wb_ready, 1'b0);
    step(1'b1, 16'h0300, {8{16'h0300}}, 1'b0, 16'h0300, 1'b0);
    chk("full_no_push_probe", probe_hit, 1'b0);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, 1'b0);
    idle(2);
    chk("full_wlog_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("full_wlog0", wlog[0], 16'h0100);
      chk("full_wlog1", wlog[1], 16'h0200);
    end
    // probe forward, newest duplicate wins
    step(1'b1, 16'h4000, LX, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h4000, LY, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, '0, 1'b0, 16'h400E, 1'b0);
    chk("probe_dup_hit", probe_hit, 1'b1);
    chk("probe_dup_line", probe_line, LY);
    step(1'b0, 16'h0, '0, 1'b0, 16'h5000, 1'b0);
    chk("probe_miss_hit", probe_hit, 1'b0);
    chk("probe_miss_line", probe_line, '0);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, 1'b0);
    // simultaneous push/pop across pointer wrap
    step(1'b1, 16'h0100, {8{16'h0100}}, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h0200 + 16'(i << 4), {8{16'(i)}}, 1'b1, 16'h0, 1'b0);
      chk("pp_addr", pmem_address, 16'h0200 + 16'(i << 4));
      chk("pp_ready", wb_ready, 1'b1);
    end
    step(1'b0, 16'h0, '0, 1'b1, 16'h0, 1'b0);
    // reset mid-drain
    step(1'b1, 16'h0100, {8{16'h0100}}, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b1);
    chk("mid_rst_write", pmem_write, 1'b0);
    step(1'b0, 16'h0, '0, 1'b1, 16'h0100, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_probe", probe_hit, 1'b0);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a, pa;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h1000 + 16'($urandom_range(0, 3) << 4) + 16'($urandom_range(0, 15));
      pa = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h1000 + 16'($urandom_range(0, 3) << 4) + 16'($urandom_range(0, 15));
      step(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
           pa, $urandom_range(0, 99) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
